// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Definitions shared by the DDR3 DMA read-side blocks: the read-arbiter state
// encoding, default address/length widths (in 512-bit words) and a helper that
// turns a requester index into a one-hot vector.
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int DDR_ADDR_W = 27;
    localparam int DDR_LEN_W  = 27;
    localparam int ID_W       = 4;

    // state       | meaning
    // ST_IDLE     | waiting for any requester, samples req/address/length
    // ST_ISSUE    | winner latched; zero-length completes here, else raise dma_req
    // ST_WAIT_ACK | dma_req held with stable address/length until dma_ack
    // ST_WAIT_EOP | transfer owned by cur_id, waiting for dout_eop
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_WAIT_EOP = 2'd3
    } rd_arb_state_t;

    function automatic logic [15:0] id_onehot(input logic [ID_W-1:0] id);
        return 16'(1) << id;
    endfunction

endpackage

// File: rtl/ddr_rd_arbiter_if.sv
// -----------------------------------------------------------------------------
// ddr_rd_arbiter_if
// Bundles the requester side (req/start_addr/length/ack/done), the DMA engine
// read-request side (dma_*) and the status outputs of the read arbiter.
//   slave  : arbiter view (requests and engine responses in, everything else out)
//   master : environment view (requesters + engine model)
// -----------------------------------------------------------------------------
interface ddr_rd_arbiter_if
    import dma_pkg::*;
#(
    parameter int N_REQ  = 16,
    parameter int ADDR_W = DDR_ADDR_W,
    parameter int LEN_W  = DDR_LEN_W
);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] start_addr;
    logic [N_REQ*LEN_W-1:0]  length;
    logic [N_REQ-1:0]        ack;
    logic [N_REQ-1:0]        done;

    logic                    dma_req;
    logic [ADDR_W-1:0]       dma_start_addr;
    logic [LEN_W-1:0]        dma_length;
    logic                    dma_ack;
    logic                    dma_eop;

    logic [ID_W-1:0]         cur_id;
    logic                    busy;
    logic                    err_timeout;

    modport slave (
        input  req, start_addr, length, dma_ack, dma_eop,
        output ack, done, dma_req, dma_start_addr, dma_length,
               cur_id, busy, err_timeout
    );

    modport master (
        output req, start_addr, length, dma_ack, dma_eop,
        input  ack, done, dma_req, dma_start_addr, dma_length,
               cur_id, busy, err_timeout
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin select: returns the first set request at or after
// i_rr_ptr, wrapping modulo N_REQ.
// Ports:
//   i_req        per-requester request vector
//   i_rr_ptr     index with highest priority this round (< N_REQ)
//   o_grant_id   winning requester index
//   o_grant_vld  at least one request set
// -----------------------------------------------------------------------------
module rr_pick
    import dma_pkg::*;
#(
    parameter int N_REQ = 16
)
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_rr_ptr,
    output logic [ID_W-1:0]  o_grant_id,
    output logic             o_grant_vld
);

    localparam logic [ID_W:0] N_VAL = (ID_W+1)'(N_REQ);

    logic [N_REQ-1:0] w_rot;
    logic [ID_W-1:0]  w_off;
    logic [ID_W:0]    w_sum;

    // Doubling the vector makes the wrap-around a plain right shift: bit 0 of
    // w_rot is requester i_rr_ptr, bit k is requester (i_rr_ptr+k) mod N_REQ.
    assign w_rot = N_REQ'({i_req, i_req} >> i_rr_ptr);

    always_comb begin
        w_off = '0;
        // Descending scan so the lowest set offset is the one left standing.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = ID_W'(i);
            end
        end
        w_sum = {1'b0, i_rr_ptr} + {1'b0, w_off};
        if (w_sum >= N_VAL) begin
            w_sum = w_sum - N_VAL;
        end
        o_grant_id = ID_W'(w_sum);
    end

    assign o_grant_vld = |i_req;

endmodule

// File: rtl/ddr_rd_arbiter.sv
// -----------------------------------------------------------------------------
// ddr_rd_arbiter
// Round-robin scheduler sharing the DDR3 DMA engine read channel among N_REQ
// level-held requesters, one transfer at a time.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus (slave)  req/start_addr/length in, ack/done pulses out,
//                dma_req/dma_start_addr/dma_length out, dma_ack/dma_eop in,
//                cur_id/busy/err_timeout status out
// TIMEOUT: cycles spent in WAIT_EOP before err_timeout sets (0 disables).
// -----------------------------------------------------------------------------
module ddr_rd_arbiter
    import dma_pkg::*;
#(
    parameter int N_REQ   = 16,
    parameter int ADDR_W  = DDR_ADDR_W,
    parameter int LEN_W   = DDR_LEN_W,
    parameter int TIMEOUT = 65535
)
(
    input  logic             clk,
    input  logic             rst_n,
    ddr_rd_arbiter_if.slave  bus
);

    localparam int              CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

    rd_arb_state_t     r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_cur_id;
    logic [ADDR_W-1:0] r_dma_addr;
    logic [LEN_W-1:0]  r_dma_len;
    logic              r_dma_req;
    logic              r_busy;
    logic              r_eop_seen;
    logic              r_err;
    logic [N_REQ-1:0]  r_ack;
    logic [N_REQ-1:0]  r_done;
    logic [CNT_W-1:0]  r_cnt;

    logic [ID_W-1:0]   w_grant_id;
    logic              w_grant_vld;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LEN_W-1:0]  w_sel_len;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [N_REQ-1:0]  w_id_oh;
    logic [ID_W-1:0]   w_next_ptr;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .i_req       (bus.req),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_id  (w_grant_id),
        .o_grant_vld (w_grant_vld)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_addr = bus.start_addr[i*ADDR_W +: ADDR_W];
                w_sel_len  = bus.length[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_id_oh    = N_REQ'(id_onehot(r_cur_id));
    assign w_next_ptr = (r_cur_id == LAST_ID) ? '0 : r_cur_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_cur_id   <= '0;
            r_dma_addr <= '0;
            r_dma_len  <= '0;
            r_dma_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_eop_seen <= 1'b0;
            r_err      <= 1'b0;
            r_ack      <= '0;
            r_done     <= '0;
            r_cnt      <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_vld) begin
                        r_cur_id   <= w_grant_id;
                        r_dma_addr <= w_sel_addr;
                        r_dma_len  <= w_sel_len;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Zero-length transfers never reach the engine.
                    if (r_dma_len == '0) begin
                        r_ack    <= w_id_oh;
                        r_done   <= w_id_oh;
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_dma_req <= 1'b1;
                        r_state   <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (bus.dma_ack) begin
                        r_dma_req  <= 1'b0;
                        r_ack      <= w_id_oh;
                        // A one-beat read can end in the ack cycle itself.
                        r_eop_seen <= bus.dma_eop;
                        r_cnt      <= '0;
                        r_state    <= ST_WAIT_EOP;
                    end
                end
                ST_WAIT_EOP: begin
                    if (bus.dma_eop || r_eop_seen) begin
                        r_done     <= w_id_oh;
                        r_rr_ptr   <= w_next_ptr;
                        r_eop_seen <= 1'b0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        // Flag only; the transfer is still allowed to finish.
                        if (TIMEOUT != 0 && w_cnt_inc == TO_VAL) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack            = r_ack;
    assign bus.done           = r_done;
    assign bus.dma_req        = r_dma_req;
    assign bus.dma_start_addr = r_dma_addr;
    assign bus.dma_length     = r_dma_len;
    assign bus.cur_id         = r_cur_id;
    assign bus.busy           = r_busy;
    assign bus.err_timeout    = r_err;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr_rd_arbiter
// Directed bench for ddr_rd_arbiter with a scoreboard of expected grants
// (id, address, length) pushed when requests are driven and popped as the
// engine model serves each transfer. Inputs change and outputs are sampled on
// the falling clock edge.
// -----------------------------------------------------------------------------
module tb_ddr_rd_arbiter;
    import dma_pkg::*;

    localparam int N_REQ = 16;
    localparam int AW    = 27;
    localparam int LW    = 27;
    localparam int TO    = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    typedef struct {
        logic [3:0]    id;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
    } exp_t;

    exp_t sb[$];

    ddr_rd_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(AW), .LEN_W(LW)) bus();

    ddr_rd_arbiter #(.N_REQ(N_REQ), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [N_REQ-1:0] oh(input logic [3:0] id);
        return N_REQ'(1) << id;
    endfunction

    task automatic set_req(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        exp_t e;
        bus.req[id] = 1'b1;
        bus.start_addr[id*AW +: AW] = addr;
        bus.length[id*LW +: LW] = len;
        e.id = 4'(id);
        e.addr = addr;
        e.len = len;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_dma_req"}, 64'(bus.dma_req), 64'(0));
        chk({tag, "_dma_addr"}, 64'(bus.dma_start_addr), 64'(0));
        chk({tag, "_dma_len"}, 64'(bus.dma_length), 64'(0));
        chk({tag, "_ack"}, 64'(bus.ack), 64'(0));
        chk({tag, "_done"}, 64'(bus.done), 64'(0));
        chk({tag, "_cur_id"}, 64'(bus.cur_id), 64'(0));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
        chk({tag, "_err"}, 64'(bus.err_timeout), 64'(0));
    endtask

    task automatic wait_dma_req();
        int n;
        n = 0;
        while (bus.dma_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("dma_req_wait", 64'(bus.dma_req), 64'(1));
    endtask

    // Pops the next expected grant, checks the issued request, acks after
    // ack_dly cycles and sends eop eop_dly cycles later (0 = with the ack).
    task automatic serve(input int ack_dly, input int eop_dly, input bit keep);
        exp_t e;
        wait_dma_req();
        chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("cur_id", 64'(bus.cur_id), 64'(e.id));
        chk("busy", 64'(bus.busy), 64'(1));
        chk("dma_addr", 64'(bus.dma_start_addr), 64'(e.addr));
        chk("dma_len", 64'(bus.dma_length), 64'(e.len));
        step(ack_dly);
        chk("dma_req_hold", 64'(bus.dma_req), 64'(1));
        chk("dma_addr_hold", 64'(bus.dma_start_addr), 64'(e.addr));
        bus.dma_ack = 1'b1;
        bus.dma_eop = (eop_dly == 0);
        step(1);
        bus.dma_ack = 1'b0;
        bus.dma_eop = 1'b0;
        if (!keep) bus.req[e.id] = 1'b0;
        chk("ack", 64'(bus.ack), 64'(oh(e.id)));
        chk("dma_req_drop", 64'(bus.dma_req), 64'(0));
        chk("done_early", 64'(bus.done), 64'(0));
        if (eop_dly > 0) begin
            step(eop_dly - 1);
            chk("done_wait", 64'(bus.done), 64'(0));
            bus.dma_eop = 1'b1;
            step(1);
            bus.dma_eop = 1'b0;
        end else begin
            step(1);
        end
        chk("done", 64'(bus.done), 64'(oh(e.id)));
        chk("ack_clear", 64'(bus.ack), 64'(0));
        chk("busy_after_done", 64'(bus.busy), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        exp_t e;
        bus.req        = '0;
        bus.start_addr = '0;
        bus.length     = '0;
        bus.dma_ack    = 1'b0;
        bus.dma_eop    = 1'b0;

        // Reset values
        step(1);
        check_all_zero("reset");
        rst_n = 1'b1;
        step(1);

        // Single request with timeline: busy at t+1, dma_req at t+2
        set_req(3, 27'h100, 27'd8);
        step(1);
        chk("t1_busy", 64'(bus.busy), 64'(1));
        chk("t1_dma_req_lo", 64'(bus.dma_req), 64'(0));
        step(1);
        chk("t2_dma_req", 64'(bus.dma_req), 64'(1));
        serve(4, 10, 1'b0);

        // All requesters asserting: grants 0..15 then 0
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, AW'(27'h1000 + i * 27'h40), LW'(4 + i));
        end
        e.id = 4'd0;
        e.addr = 27'h1000;
        e.len = 27'd4;
        sb.push_back(e);
        for (int k = 0; k <= N_REQ; k++) begin
            serve(2, 3, 1'b1);
        end
        bus.req = '0;

        // Pointer wrap: after grant 15, requests 0 and 14 -> 0 then 14
        set_req(15, 27'h2000, 27'd2);
        serve(1, 1, 1'b0);
        set_req(0, 27'h3000, 27'd3);
        set_req(14, 27'h3400, 27'd5);
        serve(1, 2, 1'b0);
        serve(1, 2, 1'b0);

        // Zero-length request: ack and done together at t+2, no dma_req
        set_req(5, 27'h5000, 27'd0);
        step(1);
        chk("z_busy", 64'(bus.busy), 64'(1));
        chk("z_dma_req_t1", 64'(bus.dma_req), 64'(0));
        step(1);
        e = sb.pop_front();
        chk("z_ack", 64'(bus.ack), 64'(oh(e.id)));
        chk("z_done", 64'(bus.done), 64'(oh(e.id)));
        chk("z_idle", 64'(bus.busy), 64'(0));
        bus.req[5] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("z_no_dma_req", 64'(bus.dma_req), 64'(0));
            step(1);
        end

        // One-beat transfer: ack and eop in the same cycle
        set_req(6, 27'h6000, 27'd1);
        serve(3, 0, 1'b0);

        // Timeout: eop withheld past TIMEOUT cycles, then delivered
        set_req(9, 27'h9000, 27'd4);
        wait_dma_req();
        e = sb.pop_front();
        chk("to_cur_id", 64'(bus.cur_id), 64'(e.id));
        bus.dma_ack = 1'b1;
        step(1);
        bus.dma_ack = 1'b0;
        bus.req[9] = 1'b0;
        chk("to_ack", 64'(bus.ack), 64'(oh(e.id)));
        step(18);
        chk("to_err_before", 64'(bus.err_timeout), 64'(0));
        step(2);
        chk("to_err_set", 64'(bus.err_timeout), 64'(1));
        chk("to_still_busy", 64'(bus.busy), 64'(1));
        chk("to_no_done", 64'(bus.done), 64'(0));
        bus.dma_eop = 1'b1;
        step(1);
        bus.dma_eop = 1'b0;
        chk("to_done", 64'(bus.done), 64'(oh(e.id)));
        chk("to_idle", 64'(bus.busy), 64'(0));
        chk("to_err_sticky", 64'(bus.err_timeout), 64'(1));

        // Reset in WAIT_EOP, then 7 wins over 12 because the pointer is 0
        set_req(2, 27'h2200, 27'd7);
        wait_dma_req();
        e = sb.pop_front();
        chk("rst_cur_id", 64'(bus.cur_id), 64'(e.id));
        bus.dma_ack = 1'b1;
        step(1);
        bus.dma_ack = 1'b0;
        bus.req[2] = 1'b0;
        step(2);
        chk("rst_busy_before", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        step(1);
        rst_n = 1'b1;
        set_req(7, 27'h700, 27'd2);
        set_req(12, 27'hC00, 27'd3);
        serve(1, 1, 1'b0);
        serve(1, 1, 1'b0);

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
